// File: rtl/smc_intadd_pkg.sv
// Shared types and constants for the intadd issue sequencer and its
// operand-read helper.
package smc_intadd_pkg;

  localparam int DATA_W    = 128;
  // Index fields are stored at a fixed width so the struct does not depend on ADDR_W.
  localparam int CMD_IDX_W = 8;

  localparam logic [1:0] PREC_8  = 2'b00;
  localparam logic [1:0] PREC_32 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_EXEC = 3'd2,
    ST_STAT = 3'd3,
    ST_WB0  = 3'd4,
    ST_WB1  = 3'd5,
    ST_RESP = 3'd6
  } state_e;

  typedef struct packed {
    logic [1:0]           prec;
    logic [2:0]           sign;
    logic [CMD_IDX_W-1:0] s0;
    logic [CMD_IDX_W-1:0] s1;
    logic [CMD_IDX_W-1:0] s2;
    logic [CMD_IDX_W-1:0] d0;
    logic [CMD_IDX_W-1:0] d1;
  } cmd_t;

  function automatic logic prec_is_legal(input logic [1:0] prec);
    return (prec == PREC_8) || (prec == PREC_32);
  endfunction

endpackage

// File: rtl/intadd_issue_rdseq.sv
// Pipelined operand reader: one register-file read per cycle, data latched
// into the operand registers one cycle later.
module intadd_issue_rdseq
  import smc_intadd_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_active,
  input  logic              i_mode8,
  input  logic [ADDR_W-1:0] i_s0_idx,
  input  logic [ADDR_W-1:0] i_s1_idx,
  input  logic [ADDR_W-1:0] i_s2_idx,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_src0,
  output logic [DATA_W-1:0] o_src1,
  output logic [DATA_W-1:0] o_src2,
  output logic              o_done
);

  logic [1:0]        r_cnt;
  logic              r_lat_vld;
  logic [1:0]        r_lat_sel;
  logic [DATA_W-1:0] r_src0;
  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;
  logic [1:0]        w_nrd;

  assign w_nrd   = i_mode8 ? 2'd3 : 2'd2;
  assign o_rd_en = i_active && (r_cnt < w_nrd);
  // The extra cycle after the last read only waits for its data to land.
  assign o_done  = i_active && (r_cnt == w_nrd);

  always_comb begin
    o_rd_addr = '0;
    if (o_rd_en) begin
      case (r_cnt)
        2'd0:    o_rd_addr = i_s0_idx;
        2'd1:    o_rd_addr = i_s1_idx;
        default: o_rd_addr = i_s2_idx;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_lat_vld <= 1'b0;
      r_lat_sel <= '0;
      r_src0    <= '0;
      r_src1    <= '0;
      r_src2    <= '0;
    end else begin
      r_lat_vld <= o_rd_en;
      r_lat_sel <= r_cnt;
      if (i_start) begin
        r_cnt  <= '0;
        r_src0 <= '0;
        r_src1 <= '0;
        r_src2 <= '0;
      end else if (i_active) begin
        r_cnt <= o_done ? 2'd0 : r_cnt + 2'd1;
      end
      if (r_lat_vld) begin
        case (r_lat_sel)
          2'd0:    r_src0 <= i_rd_data;
          2'd1:    r_src1 <= i_rd_data;
          default: r_src2 <= i_rd_data;
        endcase
      end
    end
  end

  assign o_src0 = r_src0;
  assign o_src1 = r_src1;
  assign o_src2 = r_src2;

endmodule

// File: rtl/intadd_issue.sv
// Command sequencer for intadd: reads operands, issues the add, captures
// dst/status, writes results back and returns the status word.
module intadd_issue
  import smc_intadd_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int DST_LAT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_prec,
  input  logic [2:0]        cmd_sign,
  input  logic [ADDR_W-1:0] cmd_s0_idx,
  input  logic [ADDR_W-1:0] cmd_s1_idx,
  input  logic [ADDR_W-1:0] cmd_s2_idx,
  input  logic [ADDR_W-1:0] cmd_d0_idx,
  input  logic [ADDR_W-1:0] cmd_d1_idx,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [DATA_W-1:0] src_reg0,
  output logic [DATA_W-1:0] src_reg1,
  output logic [DATA_W-1:0] src_reg2,
  output logic [1:0]        precision_s0,
  output logic [1:0]        precision_s1,
  output logic [1:0]        precision_s2,
  output logic              sign_s0,
  output logic              sign_s1,
  output logic              sign_s2,
  output logic              inst_valid,
  input  logic [DATA_W-1:0] dst_reg0,
  input  logic [DATA_W-1:0] dst_reg1,
  input  logic [DATA_W-1:0] st,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_st,
  output logic              rsp_err
);

  state_e            r_state;
  state_e            w_next;
  cmd_t              r_cmd;
  logic              r_cmd_ready;
  logic              r_err;
  logic [7:0]        r_exec_cnt;
  logic [DATA_W-1:0] r_dst0;
  logic [DATA_W-1:0] r_dst1;
  logic [DATA_W-1:0] r_st;

  logic w_accept;
  logic w_mode8;
  logic w_rd_done;
  logic w_exec_last;
  logic w_issue_ok;

  assign w_accept    = cmd_valid && r_cmd_ready && (r_state == ST_IDLE);
  assign w_mode8     = (r_cmd.prec == PREC_8);
  assign w_exec_last = (r_state == ST_EXEC) && (r_exec_cnt == 8'(DST_LAT));
  assign w_issue_ok  = !r_err;

  intadd_issue_rdseq #(
    .ADDR_W (ADDR_W)
  ) u_rdseq (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_accept && prec_is_legal(cmd_prec)),
    .i_active  (r_state == ST_RD),
    .i_mode8   (w_mode8),
    .i_s0_idx  (ADDR_W'(r_cmd.s0)),
    .i_s1_idx  (ADDR_W'(r_cmd.s1)),
    .i_s2_idx  (ADDR_W'(r_cmd.s2)),
    .i_rd_data (rf_rd_data),
    .o_rd_en   (rf_rd_en),
    .o_rd_addr (rf_rd_addr),
    .o_src0    (src_reg0),
    .o_src1    (src_reg1),
    .o_src2    (src_reg2),
    .o_done    (w_rd_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = prec_is_legal(cmd_prec) ? ST_RD : ST_RESP;
      ST_RD:   if (w_rd_done) w_next = ST_EXEC;
      ST_EXEC: if (w_exec_last) w_next = ST_STAT;
      ST_STAT: w_next = ST_WB0;
      ST_WB0:  w_next = w_mode8 ? ST_WB1 : ST_RESP;
      ST_WB1:  w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_cmd       <= '0;
      r_err       <= 1'b0;
      r_exec_cnt  <= '0;
      r_dst0      <= '0;
      r_dst1      <= '0;
      r_st        <= '0;
    end else begin
      r_state     <= w_next;
      // Registered so that it stays low through reset and rises one cycle after release.
      r_cmd_ready <= (w_next == ST_IDLE);
      if (w_accept) begin
        r_cmd <= '{prec: cmd_prec, sign: cmd_sign,
                   s0: CMD_IDX_W'(cmd_s0_idx), s1: CMD_IDX_W'(cmd_s1_idx),
                   s2: CMD_IDX_W'(cmd_s2_idx), d0: CMD_IDX_W'(cmd_d0_idx),
                   d1: CMD_IDX_W'(cmd_d1_idx)};
        r_err <= !prec_is_legal(cmd_prec);
        r_st  <= '0;
      end
      if (r_state == ST_EXEC) begin
        r_exec_cnt <= w_exec_last ? 8'd0 : r_exec_cnt + 8'd1;
      end
      if (w_exec_last) begin
        r_dst0 <= dst_reg0;
        r_dst1 <= dst_reg1;
      end
      // intadd registers st, so it is only valid during the cycle after EXEC.
      if (r_state == ST_STAT) begin
        r_st <= st;
      end
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign inst_valid   = (r_state == ST_EXEC) || (r_state == ST_STAT);
  assign precision_s0 = w_issue_ok ? r_cmd.prec : 2'b00;
  assign precision_s1 = w_issue_ok ? r_cmd.prec : 2'b00;
  assign precision_s2 = (w_issue_ok && w_mode8) ? r_cmd.prec : 2'b00;
  assign sign_s0      = w_issue_ok && r_cmd.sign[0];
  assign sign_s1      = w_issue_ok && r_cmd.sign[1];
  assign sign_s2      = w_issue_ok && r_cmd.sign[2];

  always_comb begin
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    if (r_state == ST_WB0) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = ADDR_W'(r_cmd.d0);
      rf_wr_data = r_dst0;
    end else if (r_state == ST_WB1) begin
      rf_wr_en   = 1'b1;
      rf_wr_addr = ADDR_W'(r_cmd.d1);
      rf_wr_data = r_dst1;
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_st    = r_st;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_intadd_issue.sv
// Directed bench for intadd_issue with a register-file model, a stub intadd
// and a response scoreboard.
module tb_intadd_issue;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_prec = '0;
  logic [2:0]   cmd_sign = '0;
  logic [4:0]   cmd_s0_idx = '0, cmd_s1_idx = '0, cmd_s2_idx = '0;
  logic [4:0]   cmd_d0_idx = '0, cmd_d1_idx = '0;
  logic         rf_rd_en;
  logic [4:0]   rf_rd_addr;
  logic [127:0] rf_rd_data;
  logic         rf_wr_en;
  logic [4:0]   rf_wr_addr;
  logic [127:0] rf_wr_data;
  logic [127:0] src_reg0, src_reg1, src_reg2;
  logic [1:0]   precision_s0, precision_s1, precision_s2;
  logic         sign_s0, sign_s1, sign_s2;
  logic         inst_valid;
  logic [127:0] dst_reg0, dst_reg1, st;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [127:0] rsp_st;
  logic         rsp_err;

  intadd_issue #(.ADDR_W(5), .DST_LAT(0)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_prec(cmd_prec), .cmd_sign(cmd_sign),
    .cmd_s0_idx(cmd_s0_idx), .cmd_s1_idx(cmd_s1_idx), .cmd_s2_idx(cmd_s2_idx),
    .cmd_d0_idx(cmd_d0_idx), .cmd_d1_idx(cmd_d1_idx),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .src_reg0(src_reg0), .src_reg1(src_reg1), .src_reg2(src_reg2),
    .precision_s0(precision_s0), .precision_s1(precision_s1), .precision_s2(precision_s2),
    .sign_s0(sign_s0), .sign_s1(sign_s1), .sign_s2(sign_s2),
    .inst_valid(inst_valid), .dst_reg0(dst_reg0), .dst_reg1(dst_reg1), .st(st),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_st(rsp_st), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [127:0] st; logic err; int lat; } exp_t;
  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_acc    = 0;

  // Register-file model with a tb-side preload port.
  logic [127:0] rf [32];
  logic         tb_wr_en = 1'b0;
  logic [4:0]   tb_wr_addr = '0;
  logic [127:0] tb_wr_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_wr_en) rf[tb_wr_addr] <= tb_wr_data;
    else if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    rf_rd_data <= rf_rd_en ? rf[rf_rd_addr] : {4{32'hDEADBEEF}};
  end

  // Stub intadd: combinational dst (DST_LAT=0), registered st.
  logic         stub_xor = 1'b0;
  logic [127:0] st_val = '0;
  always_comb begin
    if (stub_xor) begin
      dst_reg0 = src_reg0 ^ src_reg1;
      dst_reg1 = src_reg2;
    end else begin
      dst_reg0 = src_reg0 + src_reg1;
      dst_reg1 = ~src_reg0;
    end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= '0;
    else        st <= inst_valid ? st_val : 128'd0;
  end

  // Activity monitor.
  int rd_tot = 0, wr_tot = 0, iv_tot = 0, ovl_tot = 0, rdaw_tot = 0;
  logic         wr_seen = 1'b0;
  logic [127:0] cap_src0 = '0, cap_src2 = '0;
  logic [1:0]   cap_prec0 = '0, cap_prec2 = '0;
  logic [2:0]   cap_sign = '0;
  always @(posedge clk) begin
    if (rf_rd_en) rd_tot <= rd_tot + 1;
    if (rf_wr_en) wr_tot <= wr_tot + 1;
    if (inst_valid) iv_tot <= iv_tot + 1;
    if (rf_rd_en && rf_wr_en) ovl_tot <= ovl_tot + 1;
    if (rf_rd_en && wr_seen) rdaw_tot <= rdaw_tot + 1;
    if (cmd_valid && cmd_ready) wr_seen <= 1'b0;
    else if (rf_wr_en) wr_seen <= 1'b1;
    if (inst_valid) begin
      cap_src0  <= src_reg0;
      cap_src2  <= src_reg2;
      cap_prec0 <= precision_s0;
      cap_prec2 <= precision_s2;
      cap_sign  <= {sign_s2, sign_s1, sign_s0};
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rf_poke(input int addr, input logic [127:0] data);
    tb_wr_en   = 1'b1;
    tb_wr_addr = 5'(addr);
    tb_wr_data = data;
    tick();
    tb_wr_en   = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] prec, input logic [2:0] sgn,
                          input int s0, input int s1, input int s2, input int d0, input int d1,
                          input logic push, input logic [127:0] e_st, input logic e_err,
                          input int e_lat);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("cmd_ready_before_accept", 128'(cmd_ready), 128'd1);
    cmd_prec = prec;  cmd_sign = sgn;
    cmd_s0_idx = 5'(s0); cmd_s1_idx = 5'(s1); cmd_s2_idx = 5'(s2);
    cmd_d0_idx = 5'(d0); cmd_d1_idx = 5'(d1);
    cmd_valid = 1'b1;
    if (push) sb.push_back('{e_st, e_err, e_lat});
    tick();
    t_acc     = cyc;
    cmd_valid = 1'b0;
  endtask

  // Latency is counted in clock edges after the accepting edge: an illegal
  // command's response is already up in the cycle right after the accept cycle.
  task automatic wait_rsp(input string tag, input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    chk({tag, "_rsp_valid"}, 128'(rsp_valid), 128'd1);
    chk({tag, "_latency"}, 128'(cyc - t_acc), 128'(e.lat));
    chk({tag, "_rsp_st"}, rsp_st, e.st);
    chk({tag, "_rsp_err"}, 128'(rsp_err), 128'(e.err));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 128'(rsp_valid), 128'd1);
      chk({tag, "_hold_st"}, rsp_st, e.st);
      chk({tag, "_hold_cmd_ready"}, 128'(cmd_ready), 128'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk({tag, "_rsp_drop"}, 128'(rsp_valid), 128'd0);
    chk({tag, "_cmd_ready_back"}, 128'(cmd_ready), 128'd1);
  endtask

  localparam logic [127:0] V1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] V2  = 128'h0F0F_0F0F_F0F0_F0F0_1111_2222_3333_4444;
  localparam logic [127:0] V3  = 128'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0;
  localparam logic [127:0] W8  = 128'h8888_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] W9  = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
  localparam logic [127:0] W10 = 128'h1010_1010_2020_2020_3030_3030_4040_4040;
  localparam logic [127:0] MK  = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;

  int rd0, wr0, iv0;

  initial begin
    // Reset and preload
    rf_poke(1, 128'd5);
    rf_poke(2, 128'd3);
    rf_poke(4, MK);
    rf_poke(6, MK);
    rf_poke(12, MK);
    chk("rst_cmd_ready", 128'(cmd_ready), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_inst_valid", 128'(inst_valid), 128'd0);
    chk("rst_rf_strobes", 128'({rf_rd_en, rf_wr_en}), 128'd0);
    chk("rst_src_reg0", src_reg0, 128'd0);
    rst_n = 1'b1;
    chk("rst_release_cmd_ready_low", 128'(cmd_ready), 128'd0);
    tick();
    chk("rst_release_cmd_ready_high", 128'(cmd_ready), 128'd1);

    // 32-bit add: 5 + 3 -> RF[4]
    stub_xor = 1'b0;
    st_val   = 128'hA5;
    rd0 = rd_tot; wr0 = wr_tot; iv0 = iv_tot;
    send_cmd(2'b11, 3'b011, 1, 2, 0, 4, 6, 1'b1, 128'hA5, 1'b0, 6);
    wait_rsp("add32", 0);
    chk("add32_rf4", rf[4], 128'd8);
    chk("add32_rf6_untouched", rf[6], MK);
    chk("add32_iv_cycles", 128'(iv_tot - iv0), 128'd2);
    chk("add32_reads", 128'(rd_tot - rd0), 128'd2);
    chk("add32_writes", 128'(wr_tot - wr0), 128'd1);
    chk("add32_prec0", 128'(cap_prec0), 128'h3);
    chk("add32_prec2", 128'(cap_prec2), 128'h0);
    chk("add32_src2", cap_src2, 128'd0);
    chk("add32_sign", 128'(cap_sign), 128'h3);

    // 8-bit mode, three sources, two destinations
    rf_poke(1, V1);
    rf_poke(2, V2);
    rf_poke(3, V3);
    stub_xor = 1'b1;
    st_val   = 128'h5A5A_0000_0000_0000_0000_0000_0000_1234;
    rd0 = rd_tot; wr0 = wr_tot; iv0 = iv_tot;
    send_cmd(2'b00, 3'b101, 1, 2, 3, 4, 5, 1'b1, st_val, 1'b0, 8);
    wait_rsp("add8", 0);
    chk("add8_rf4", rf[4], V1 ^ V2);
    chk("add8_rf5", rf[5], V3);
    chk("add8_reads", 128'(rd_tot - rd0), 128'd3);
    chk("add8_writes", 128'(wr_tot - wr0), 128'd2);
    chk("add8_iv_cycles", 128'(iv_tot - iv0), 128'd2);
    chk("add8_sign", 128'(cap_sign), 128'h5);
    chk("add8_src2", cap_src2, V3);

    // Illegal precision
    rd0 = rd_tot; wr0 = wr_tot; iv0 = iv_tot;
    send_cmd(2'b01, 3'b111, 1, 2, 3, 4, 5, 1'b1, 128'd0, 1'b1, 0);
    wait_rsp("illegal", 0);
    chk("illegal_reads", 128'(rd_tot - rd0), 128'd0);
    chk("illegal_writes", 128'(wr_tot - wr0), 128'd0);
    chk("illegal_iv", 128'(iv_tot - iv0), 128'd0);

    // Response backpressure, then a command accepted right after release
    stub_xor  = 1'b0;
    st_val    = 128'h77;
    rsp_ready = 1'b0;
    send_cmd(2'b11, 3'b000, 1, 2, 0, 13, 0, 1'b1, 128'h77, 1'b0, 6);
    wait_rsp("bp", 5);
    st_val = 128'h78;
    send_cmd(2'b11, 3'b000, 2, 1, 0, 14, 0, 1'b1, 128'h78, 1'b0, 6);
    wait_rsp("bp_next", 0);
    chk("bp_rf13", rf[13], V1 + V2);
    chk("bp_rf14", rf[14], V2 + V1);

    // d0 == d1: the second write is the one that sticks
    stub_xor = 1'b1;
    st_val   = 128'h99;
    send_cmd(2'b00, 3'b000, 1, 2, 3, 7, 7, 1'b1, 128'h99, 1'b0, 8);
    wait_rsp("same_dst", 0);
    chk("same_dst_rf7", rf[7], V3);

    // Destination aliases a source
    rf_poke(8, W8);
    rf_poke(9, W9);
    rf_poke(10, W10);
    send_cmd(2'b00, 3'b010, 8, 9, 10, 8, 11, 1'b1, 128'h99, 1'b0, 8);
    wait_rsp("alias", 0);
    chk("alias_src0", cap_src0, W8);
    chk("alias_rf8", rf[8], W8 ^ W9);
    chk("alias_rf11", rf[11], W10);

    // Reset in the middle of EXEC
    stub_xor = 1'b0;
    wr0 = wr_tot;
    send_cmd(2'b11, 3'b000, 1, 2, 0, 12, 0, 1'b0, 128'd0, 1'b0, 0);
    begin
      int n;
      n = 0;
      while (inst_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
    end
    chk("midrst_reached_exec", 128'(inst_valid), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_inst_valid", 128'(inst_valid), 128'd0);
    chk("midrst_src_reg0", src_reg0, 128'd0);
    chk("midrst_prec_sign", 128'({precision_s0, sign_s0, sign_s1}), 128'd0);
    chk("midrst_cmd_ready", 128'(cmd_ready), 128'd0);
    tick();
    tick();
    tick();
    chk("midrst_no_rsp", 128'(rsp_valid), 128'd0);
    chk("midrst_no_write", 128'(wr_tot - wr0), 128'd0);
    chk("midrst_rf12", rf[12], MK);
    rst_n = 1'b1;
    tick();
    st_val = 128'hC3;
    send_cmd(2'b11, 3'b000, 1, 2, 0, 12, 0, 1'b1, 128'hC3, 1'b0, 6);
    wait_rsp("after_rst", 0);
    chk("after_rst_rf12", rf[12], V1 + V2);

    chk("never_rd_and_wr", 128'(ovl_tot), 128'd0);
    chk("no_read_after_write", 128'(rdaw_tot), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/intadd_issue.md
Name: intadd_issue

Overview:
- Initiator/sequencer for the intadd datapath. It accepts one add command at a time over a valid/ready channel, reads operands from the SMC vector register file, and drives the intadd src/precision/sign/inst_valid interface.
- It captures dst_reg0/dst_reg1 and the registered st, writes the results back to the register file, and returns the status word on a response channel.
- Sits between the SMC instruction decoder and intadd.

Parameters:
- ADDR_W, 5, register-file index width.
- DST_LAT, 0, cycles from inst_valid assertion until dst_reg0/1 are valid (0 = same cycle).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept command
- cmd_prec  in  2  mode: 00 = 4+8-bit (three sources), 11 = 32-bit (two sources), others illegal
- cmd_sign  in  3  sign flags for s2,s1,s0
- cmd_s0_idx, cmd_s1_idx, cmd_s2_idx  in  ADDR_W each  source register indices
- cmd_d0_idx, cmd_d1_idx  in  ADDR_W each  destination register indices
- rf_rd_en  out  1  register-file read strobe
- rf_rd_addr  out  ADDR_W  read index
- rf_rd_data  in  128  read data, valid one cycle after rf_rd_en
- rf_wr_en  out  1  write strobe
- rf_wr_addr  out  ADDR_W  write index
- rf_wr_data  out  128  write data
- src_reg0, src_reg1, src_reg2  out  128 each  intadd operands
- precision_s0, precision_s1, precision_s2  out  2 each  intadd precision
- sign_s0, sign_s1, sign_s2  out  1 each  intadd sign
- inst_valid  out  1  intadd issue strobe
- dst_reg0, dst_reg1, st  in  128 each  intadd results
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_st  out  128  captured status
- rsp_err  out  1  illegal precision

Behaviour:
- Reset values (async): every output is 0; FSM is in IDLE.
  - cmd_ready is also 0 during reset and rises the first cycle after release.
  - Reset mid-operation aborts immediately: no write, no response.
- FSM states: IDLE, RD, EXEC, STAT, WB0, WB1, RESP.
- IDLE:
  - cmd_ready=1. On cmd_valid&cmd_ready, latch all command fields.
  - Legal prec -> RD. Illegal prec -> RESP with rsp_err=1 and rsp_st=0; no intadd issue, no RF access.
- RD: pipelined reads, one rf_rd_en per cycle, in order s0, s1, then s2 (8-bit mode only).
  - Data returned the next cycle is latched into src_reg0/1/2.
  - RD lasts N+1 cycles (N = 3 for 8-bit, N = 2 for 32-bit).
  - In 32-bit mode src_reg2=0 and precision_s2=00.
- Operands and control hold stable from end of RD until leaving STAT:
  - precision_s0/s1 = latched prec.
  - precision_s2 = prec in 8-bit mode.
  - sign_sX = latched cmd_sign bits.
- EXEC:
  - inst_valid=1 for DST_LAT+1 cycles.
  - On the last EXEC cycle, latch dst_reg0 and dst_reg1.
- STAT:
  - inst_valid stays 1 for exactly one more cycle (required by intadd's registered st).
  - Latch st at the end of this cycle, then -> WB0.
- WB0: rf_wr_en=1, addr d0, data = latched dst0.
  - 8-bit mode -> WB1; 32-bit mode -> RESP (dst1 discarded).
- WB1: write d1 with latched dst1, then -> RESP.
  - If d0==d1, the WB1 value is final (last write wins).
  - Destination equal to a source is legal: all reads complete before any write.
- RESP: rsp_valid=1 with rsp_st/rsp_err held stable until rsp_ready.
  - Handshake cycle -> IDLE; rsp_valid drops the next cycle.
- Throughput: one command in flight; cmd_ready=0 outside IDLE.
- Latency, command accept to rsp_valid with DST_LAT=0:
  - 8-bit: 4 RD + 1 EXEC + 1 STAT + 2 WB = 8 cycles.
  - 32-bit: 3 RD + 1 EXEC + 1 STAT + 1 WB = 6 cycles.
- rf_rd_en and rf_wr_en are never asserted in the same cycle.

Decomposition:
- Shared package smc_intadd_pkg holds:
  - state enum;
  - precision constants PREC_8=2'b00 and PREC_32=2'b11;
  - the 128-bit data-width constant;
  - a command struct (prec, sign, five indices).
- One natural sub-module, intadd_issue_rdseq: the pipelined operand-read sequencer (address counter, 1-cycle data alignment, operand latches). The FSM, capture and writeback stay in the top.

Test Plan:
- 32-bit command, RF[1]=0x...0005, RF[2]=0x...0003, stub intadd dst0=src0+src1, st=0xA5 one cycle after inst_valid:
  - RF[4]=0x...0008.
  - rsp_st=0xA5, rsp_err=0.
  - rsp_valid 6 cycles after accept.
  - inst_valid high exactly 2 cycles.
- 8-bit command, s0/s1/s2=1/2/3, d0=4, d1=5, stub dst0=src0^src1, dst1=src2:
  - RF[4] and RF[5] hold the expected values.
  - Exactly 3 reads, then exactly 2 writes; rsp after 8 cycles.
- cmd_prec=01 -> rsp_err=1, rsp_st=0, inst_valid never asserted, no RF strobes, rsp after 1 cycle.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_st stable, cmd_ready=0 throughout; accepted cycle after release.
- d0==d1=7 in 8-bit mode -> RF[7] ends with dst1 value.
- d0==s0 -> reads are unaffected.
- rst_n asserted during EXEC -> all outputs 0 immediately, no write or response; a new command after reset completes normally.
